// File: rtl/instr_encoder.sv
// Instruction encoder: packs field-level entries into 32-bit instruction words and
// streams them into instruction memory at consecutive word addresses per session.
module instr_encoder #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_kind,
    input  logic [3:0]  in_cmd,
    input  logic        in_s,
    input  logic        in_imm,
    input  logic        in_load,
    input  logic        in_link,
    input  logic        in_last,
    input  logic [3:0]  in_cond,
    input  logic [3:0]  in_rn,
    input  logic [3:0]  in_rd,
    input  logic [3:0]  in_rm,
    input  logic [11:0] in_imm12,
    input  logic [23:0] in_imm24,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [10:0] count
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] addr;
    logic [31:0] encoded;
    logic        legal;
    logic        accept;
    logic        at_limit;

    assign accept   = in_ready & in_valid;
    assign at_limit = (count == 11'(DEPTH - 1));

    // Only AND, SUB, ADD, ORR and MOV are supported among data-processing commands.
    always_comb begin
        encoded = '0;
        legal   = 1'b0;
        case (in_kind)
            2'b00: begin
                encoded = {in_cond, 2'b00, in_imm, in_cmd, in_s, in_rn, in_rd,
                           (in_imm ? in_imm12 : {8'b0, in_rm})};
                legal   = in_cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1101};
            end
            2'b01: begin
                encoded = {in_cond, 2'b01, 5'b01100, in_load, in_rn, in_rd, in_imm12};
                legal   = 1'b1;
            end
            2'b10: begin
                encoded = {in_cond, 2'b10, 1'b1, in_link, in_imm24};
                legal   = 1'b1;
            end
            default: begin
                encoded = '0;
                legal   = 1'b0;
            end
        endcase
    end

    // A write issues in the cycle after acceptance, so FLUSH lasts exactly one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            addr     <= '0;
            count    <= '0;
            err      <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= RUN;
                        addr     <= base_addr;
                        count    <= '0;
                        err      <= 1'b0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (legal) begin
                            wr_en   <= 1'b1;
                            wr_addr <= addr;
                            wr_data <= encoded;
                            addr    <= addr + 32'd4;
                            count   <= count + 11'd1;
                        end else begin
                            err <= 1'b1;
                        end
                        if (in_last || (legal && at_limit)) begin
                            state    <= FLUSH;
                            in_ready <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural session model.
module tb_instr_encoder;

    localparam int DEPTH   = 4;
    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_FLUSH = 2;
    localparam int P_DONE  = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_kind = '0;
    logic [3:0]  in_cmd = '0;
    logic        in_s = 1'b0, in_imm = 1'b0, in_load = 1'b0, in_link = 1'b0, in_last = 1'b0;
    logic [3:0]  in_cond = '0, in_rn = '0, in_rd = '0, in_rm = '0;
    logic [11:0] in_imm12 = '0;
    logic [23:0] in_imm24 = '0;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy, done, err;
    logic [10:0] count;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    int          m_phase = P_IDLE;
    logic [31:0] m_addr  = '0;
    int          m_count = 0;
    bit          m_err   = 1'b0;
    wr_t         exp_q[$];

    instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_cmd(in_cmd),
        .in_s(in_s), .in_imm(in_imm), .in_load(in_load), .in_link(in_link), .in_last(in_last),
        .in_cond(in_cond), .in_rn(in_rn), .in_rd(in_rd), .in_rm(in_rm),
        .in_imm12(in_imm12), .in_imm24(in_imm24),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Instruction word built by weighting each field with its bit position.
    function automatic logic [31:0] ref_encode();
        logic [31:0] w;
        w = 32'(in_cond) * 32'h1000_0000;
        case (in_kind)
            2'd0: w = w + 32'(in_imm) * 32'h0200_0000 + 32'(in_cmd) * 32'h0020_0000
                      + 32'(in_s) * 32'h0010_0000 + 32'(in_rn) * 32'h0001_0000
                      + 32'(in_rd) * 32'h0000_1000 + (in_imm ? 32'(in_imm12) : 32'(in_rm));
            2'd1: w = w + 32'h0400_0000 + (32'd24 + 32'(in_load)) * 32'h0010_0000
                      + 32'(in_rn) * 32'h0001_0000 + 32'(in_rd) * 32'h0000_1000 + 32'(in_imm12);
            2'd2: w = w + 32'h0800_0000 + 32'h0200_0000 + 32'(in_link) * 32'h0100_0000
                      + 32'(in_imm24);
            default: w = '0;
        endcase
        return w;
    endfunction

    function automatic bit ref_legal();
        if (in_kind == 2'd3) return 1'b0;
        if (in_kind == 2'd0)
            return (in_cmd == 4'd4) || (in_cmd == 4'd2) || (in_cmd == 4'd0) ||
                   (in_cmd == 4'd12) || (in_cmd == 4'd13);
        return 1'b1;
    endfunction

    task automatic model_clear();
        m_phase = P_IDLE;
        m_addr  = '0;
        m_count = 0;
        m_err   = 1'b0;
        exp_q.delete();
    endtask

    // One clock edge of session behaviour, applied to the inputs as currently driven.
    task automatic model_step();
        if (reset) begin
            model_clear();
            return;
        end
        case (m_phase)
            P_IDLE, P_DONE: begin
                if (start) begin
                    m_phase = P_RUN;
                    m_addr  = base_addr;
                    m_count = 0;
                    m_err   = 1'b0;
                end
            end
            P_RUN: begin
                if (in_valid) begin
                    if (ref_legal()) begin
                        exp_q.push_back('{a: m_addr, d: ref_encode()});
                        m_addr  = m_addr + 32'd4;
                        m_count = m_count + 1;
                    end else begin
                        m_err = 1'b1;
                    end
                    if (in_last || m_count == DEPTH) m_phase = P_FLUSH;
                end
            end
            default: m_phase = P_DONE;
        endcase
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic compare_outputs();
        check("in_ready", in_ready, m_phase == P_RUN);
        check("busy", busy, (m_phase == P_RUN) || (m_phase == P_FLUSH));
        check("done", done, m_phase == P_DONE);
        check("err", err, m_err);
        check("count", count, 32'(m_count));
        if (exp_q.size() > 0) begin
            check("wr_en", wr_en, 1'b1);
            if (wr_en) begin
                check("wr_addr", wr_addr, exp_q[0].a);
                check("wr_data", wr_data, exp_q[0].d);
            end
            void'(exp_q.pop_front());
        end else begin
            check("wr_en", wr_en, 1'b0);
        end
    endtask

    always @(negedge clk) compare_outputs();

    task automatic drive_entry(input logic [1:0] kind, input logic [3:0] cmd, input logic [3:0] cond,
                               input logic s, input logic imm, input logic load, input logic link,
                               input logic [3:0] rn, input logic [3:0] rd, input logic [3:0] rm,
                               input logic [11:0] imm12, input logic [23:0] imm24, input logic last);
        in_valid = 1'b1;
        in_kind  = kind;  in_cmd  = cmd;   in_cond  = cond;
        in_s     = s;     in_imm  = imm;   in_load  = load;  in_link = link;
        in_rn    = rn;    in_rd   = rd;    in_rm    = rm;
        in_imm12 = imm12; in_imm24 = imm24; in_last = last;
    endtask

    task automatic begin_session(input logic [31:0] base);
        start     = 1'b1;
        base_addr = base;
        in_valid  = 1'b0;
        cycle();
        start = 1'b0;
    endtask

    initial begin
        int n_wr;
        @(negedge clk);
        #1;
        cycle();
        cycle();
        reset = 1'b0;
        check("rst_count", count, 0);
        check("rst_ready", in_ready, 0);
        check("rst_wr_data", wr_data, 0);

        // Single ADD with immediate
        begin_session(32'h100);
        check("t1_ready", in_ready, 1);
        drive_entry(2'd0, 4'b0100, 4'hE, 1, 1, 0, 0, 4'd1, 4'd2, 4'd0, 12'h005, 24'h0, 1);
        check("model_add", ref_encode(), 32'hE2912005);
        cycle();
        in_valid = 1'b0;
        check("t1_wr_en", wr_en, 1);
        check("t1_wr_addr", wr_addr, 32'h100);
        check("t1_wr_data", wr_data, 32'hE2912005);
        cycle();
        check("t1_done", done, 1);
        check("t1_count", count, 1);

        // LDR, STR, BL back to back
        begin_session(32'h100);
        drive_entry(2'd1, 4'd0, 4'hE, 0, 0, 1, 0, 4'd0, 4'd3, 4'd0, 12'h008, 24'h0, 0);
        check("model_ldr", ref_encode(), 32'hE5903008);
        cycle();
        check("t2_wr0_en", wr_en, 1);
        check("t2_wr0_addr", wr_addr, 32'h100);
        check("t2_wr0_data", wr_data, 32'hE5903008);
        drive_entry(2'd1, 4'd0, 4'hE, 0, 0, 0, 0, 4'd1, 4'd4, 4'd0, 12'h004, 24'h0, 0);
        cycle();
        check("t2_wr1_en", wr_en, 1);
        check("t2_wr1_addr", wr_addr, 32'h104);
        check("t2_wr1_data", wr_data, 32'hE5814004);
        drive_entry(2'd2, 4'd0, 4'hE, 0, 0, 0, 1, 4'd0, 4'd0, 4'd0, 12'h0, 24'h000010, 1);
        check("model_bl", ref_encode(), 32'hEB000010);
        cycle();
        in_valid = 1'b0;
        check("t2_wr2_en", wr_en, 1);
        check("t2_wr2_addr", wr_addr, 32'h108);
        check("t2_wr2_data", wr_data, 32'hEB000010);
        check("t2_ready_low", in_ready, 0);
        cycle();
        check("t2_done", done, 1);
        check("t2_count", count, 3);

        // Illegal kind and unsupported command are consumed without writes
        begin_session(32'h200);
        drive_entry(2'd3, 4'd4, 4'hE, 0, 0, 0, 0, 4'd1, 4'd2, 4'd3, 12'h0, 24'h0, 0);
        cycle();
        check("t3_skip0_wr", wr_en, 0);
        check("t3_err0", err, 1);
        drive_entry(2'd0, 4'b0111, 4'hE, 0, 0, 0, 0, 4'd1, 4'd2, 4'd3, 12'h0, 24'h0, 0);
        cycle();
        check("t3_skip1_wr", wr_en, 0);
        check("t3_count0", count, 0);
        drive_entry(2'd0, 4'b0010, 4'hE, 0, 0, 0, 0, 4'd1, 4'd2, 4'd5, 12'h0, 24'h0, 1);
        cycle();
        in_valid = 1'b0;
        check("t3_wr_en", wr_en, 1);
        check("t3_wr_addr", wr_addr, 32'h200);
        check("t3_wr_data", wr_data, 32'hE0412005);
        cycle();
        check("t3_err_sticky", err, 1);
        check("t3_count", count, 1);

        // Depth limit with no last marker
        begin_session(32'h0);
        n_wr = 0;
        for (int i = 0; i < 6; i++) begin
            drive_entry(2'd0, 4'b1101, 4'hE, 0, 1, 0, 0, 4'd0, 4'd1, 4'd0, 12'(i), 24'h0, 0);
            cycle();
            if (wr_en) n_wr++;
            if (i == 3) check("t4_ready_drop", in_ready, 0);
        end
        in_valid = 1'b0;
        cycle();
        check("t4_writes", n_wr, 4);
        check("t4_done", done, 1);
        check("t4_count", count, 4);

        // Reset between acceptance and write
        begin_session(32'h300);
        drive_entry(2'd1, 4'd0, 4'hE, 0, 0, 1, 0, 4'd2, 4'd3, 4'd0, 12'h010, 24'h0, 0);
        #1;
        reset = 1'b1;
        model_clear();
        #1;
        check("t5_wr_en", wr_en, 0);
        check("t5_ready", in_ready, 0);
        check("t5_busy", busy, 0);
        check("t5_count", count, 0);
        check("t5_wr_addr", wr_addr, 0);
        check("t5_wr_data", wr_data, 0);
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t5_idle_ready", in_ready, 0);
            check("t5_idle_wr", wr_en, 0);
        end
        in_valid = 1'b0;

        // Randomized traffic with stalls and stray start pulses
        for (int i = 0; i < 2500; i++) begin
            start     = ($urandom_range(0, 7) == 0);
            base_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : $urandom;
            in_valid  = ($urandom_range(0, 9) < 7);
            in_kind   = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            case ($urandom_range(0, 5))
                0: in_cmd = 4'd4;
                1: in_cmd = 4'd2;
                2: in_cmd = 4'd13;
                default: in_cmd = 4'($urandom);
            endcase
            in_cond  = 4'($urandom);
            in_s     = 1'($urandom);
            in_imm   = 1'($urandom);
            in_load  = 1'($urandom);
            in_link  = 1'($urandom);
            in_rn    = 4'($urandom);
            in_rd    = 4'($urandom);
            in_rm    = 4'($urandom);
            in_imm12 = 12'($urandom);
            in_imm24 = 24'($urandom);
            in_last  = ($urandom_range(0, 9) == 0);
            cycle();
        end
        in_valid = 1'b0;
        start    = 1'b0;
        cycle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Parameters
REQ-001 SHALL have parameter DEPTH, default 64, meaning the maximum number of words written per session (range 2..1024).

Interface
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, which begins a programming session from IDLE or DONE.
REQ-005 SHALL have port base_addr, input, 32, the byte address of the first word, sampled on start.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1), the entry handshake.
REQ-007 SHALL have port in_kind, input, 2: 00 data-processing, 01 memory, 10 branch, 11 illegal.
REQ-008 SHALL have port in_cmd, input, 4, the data-processing command.
REQ-009 SHALL have single-bit input ports in_s, in_imm, in_load, in_link and in_last.
REQ-010 SHALL have input ports in_cond (4), in_rn (4), in_rd (4), in_rm (4), in_imm12 (12) and in_imm24 (24).
REQ-011 SHALL have output ports wr_en (1), wr_addr (32) and wr_data (32), the instruction-memory write port.
REQ-012 SHALL have output ports busy (1), done (1), err (1) and count (11).

Function
REQ-013 SHALL implement FSM states IDLE, RUN, FLUSH and DONE.
- IDLE or DONE with start=1 -> RUN; addr=base_addr; count=0; err=0.
REQ-014 SHALL assert in_ready only in RUN; an entry is accepted when in_valid&in_ready.
REQ-015 SHALL encode a kind-00 entry as {cond,2'b00,imm,cmd,s,rn,rd,src}.
- src = imm ? imm12 : {8'b0,rm}.
REQ-016 SHALL encode a kind-01 entry as {cond,2'b01,6'b011000|load,rn,rd,imm12}, i.e. Funct = {0,1,1,0,0,L}.
REQ-017 SHALL encode a kind-10 entry as {cond,2'b10,1'b1,link,imm24}.
REQ-018 SHALL treat an entry as legal only if:
- kind is 00, 01 or 10; and
- for kind 00, cmd is one of 0100, 0010, 0000, 1100, 1101.
REQ-019 SHALL register every legal accepted entry and pulse wr_en the following cycle (latency 1).
- wr_data = the encoded word; wr_addr = current addr.
- addr += 4 (32-bit wrap); count += 1.
REQ-020 SHALL consume an illegal entry without writing it, leave addr and count unchanged, and set err sticky until the next start.
REQ-021 SHALL, on accepting an entry with in_last=1, or the entry that brings count to DEPTH, go to FLUSH.
- This applies whether the entry is legal or illegal.
REQ-022 SHALL remain in FLUSH until the pending write has issued, then go to DONE; with no pending write it goes to DONE the next cycle.
REQ-023 SHALL hold done=1 in DONE only; busy=1 in RUN and FLUSH.
REQ-024 SHALL ignore start while in RUN or FLUSH.
REQ-025 SHALL drive wr_en=0 whenever no write is pending; wr_addr and wr_data are don't-care then.
REQ-026 SHALL support back-to-back acceptance at one entry per cycle with no bubbles.
REQ-027 SHALL report count as the number of words written in the current session, 0..DEPTH.

Reset
REQ-028 SHALL, on reset, asynchronously enter IDLE and clear all state.
- Outputs: in_ready=0, wr_en=0, busy=0, done=0, err=0, count=0, wr_addr=0, wr_data=0.
- Any pending write is discarded.
REQ-029 SHALL, after reset deasserts, require a start to begin any session.

Verification
REQ-030 SHALL pass: start, base_addr=0x100; DP ADD, imm=1, s=1, cond=E, rn=1, rd=2, imm12=0x005, last=1.
- Response: one cycle later wr_en=1, wr_addr=0x100, wr_data=0xE2912005; then done=1, count=1.
REQ-031 SHALL pass: three back-to-back entries (LDR rn=0 rd=3 imm12=8; STR; B link=1 imm24=0x000010), last on the third.
- Response: wr_en high for 3 consecutive cycles at 0x100/0x104/0x108.
- LDR word = 0xE5903008; B word = 0xEB000010.
REQ-032 SHALL pass: an entry with kind=11, then a DP entry with cmd=0111, then a valid entry.
- Response: no write for the first two; err=1 stays high.
- The valid entry is written at base_addr; count=1.
REQ-033 SHALL pass: DEPTH=4, six entries offered with no in_last.
- Response: exactly 4 writes; in_ready drops after the 4th; DONE reached with count=4.
REQ-034 SHALL pass: reset asserted in the cycle between acceptance and the write.
- Response: wr_en never pulses; all outputs zero immediately (async); the FSM stays in IDLE until start.
REQ-035 SHALL pass: in_valid toggled randomly with in_ready stalls and start pulsed during RUN.
- Response: start is ignored; each accepted entry is written exactly once, in order, at consecutive addresses.
